// File: rtl/sec32_pkg.sv
// Shared definitions for the 32-bit SEC check encoder and its corrector.
// Holds the check-bit equations as masks, the word bundle type and helper functions.
package sec32_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int INJ_W  = DATA_W + CHK_W;
  localparam int NIB_N  = DATA_W / 4;
  localparam int COL_N  = 4;

  localparam logic [5:0] INJ_SEL_MAX = 6'd39;

  // Bit i of CHK_MASK[c] is set when data bit i participates in check bit c.
  localparam logic [DATA_W-1:0] CHK_MASK [CHK_W] = '{
    32'h00FF_1111,
    32'hFF00_2222,
    32'h0F0F_4444,
    32'hF0F0_8888,
    32'h1111_00FF,
    32'h2222_FF00,
    32'h4444_0F0F,
    32'h8888_F0F0
  };

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CHK_W-1:0]  check;
  } sec32_word_t;

  // Folds nibble parities and the lower/upper column parities into c[7:0].
  function automatic logic [CHK_W-1:0] sec32_combine(
    input logic [NIB_N-1:0] nib,
    input logic [COL_N-1:0] col_lo,
    input logic [COL_N-1:0] col_hi
  );
    logic [CHK_W-1:0] c;
    c[0] = nib[4] ^ nib[5] ^ col_lo[0];
    c[1] = nib[6] ^ nib[7] ^ col_lo[1];
    c[2] = nib[4] ^ nib[6] ^ col_lo[2];
    c[3] = nib[5] ^ nib[7] ^ col_lo[3];
    c[4] = nib[0] ^ nib[1] ^ col_hi[0];
    c[5] = nib[2] ^ nib[3] ^ col_hi[1];
    c[6] = nib[0] ^ nib[2] ^ col_hi[2];
    c[7] = nib[1] ^ nib[3] ^ col_hi[3];
    return c;
  endfunction

  // Flat mask-based evaluation, convenient for reference models.
  function automatic logic [CHK_W-1:0] sec32_check_flat(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c;
    c = '0;
    for (int k = 0; k < CHK_W; k++) begin
      c[k] = ^(d & CHK_MASK[k]);
    end
    return c;
  endfunction

  // One-hot flip mask over {check, data}; sel must already be <= INJ_SEL_MAX.
  function automatic logic [INJ_W-1:0] sec32_inj_mask(input logic [5:0] sel);
    logic [INJ_W-1:0] m;
    m = {{(INJ_W-1){1'b0}}, 1'b1} << sel;
    return m;
  endfunction

endpackage

// File: rtl/sec32_parity_tree.sv
// Combinational nibble and column parities of a 32-bit word.
// Column parities are split into the lower and upper 16-bit halves.
module sec32_parity_tree
  import sec32_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [NIB_N-1:0]  nib_par_o,
  output logic [COL_N-1:0]  col_lo_o,
  output logic [COL_N-1:0]  col_hi_o
);

  always_comb begin
    nib_par_o = '0;
    col_lo_o  = '0;
    col_hi_o  = '0;
    for (int k = 0; k < NIB_N; k++) begin
      nib_par_o[k] = ^data_i[4*k +: 4];
    end
    // Column j gathers bits j, j+4, j+8, j+12 within each 16-bit half.
    for (int j = 0; j < COL_N; j++) begin
      col_lo_o[j] = data_i[j]      ^ data_i[j+4]    ^ data_i[j+8]    ^ data_i[j+12];
      col_hi_o[j] = data_i[16+j]   ^ data_i[16+j+4] ^ data_i[16+j+8] ^ data_i[16+j+12];
    end
  end

endmodule

// File: rtl/sec32_check_encoder.sv
// Two-stage valid/ready encoder producing the SEC check bits for a 32-bit word,
// with a one-shot single-bit error-injection hook and a delivered-word counter.
module sec32_check_encoder
  import sec32_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_check,
  output logic              out_en,
  input  logic              inj_arm,
  input  logic [5:0]        inj_sel,
  output logic              inj_pending,
  output logic [CNT_W-1:0]  word_cnt
);

  logic [NIB_N-1:0]  nib_par_s;
  logic [COL_N-1:0]  col_lo_s;
  logic [COL_N-1:0]  col_hi_s;

  logic              s2_load_s;
  logic              s1_adv_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic              arm_ok_s;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [NIB_N-1:0]  s1_nib_q,   s1_nib_d;
  logic [COL_N-1:0]  s1_clo_q,   s1_clo_d;
  logic [COL_N-1:0]  s1_chi_q,   s1_chi_d;
  logic [INJ_W-1:0]  s1_mask_q,  s1_mask_d;

  logic              out_valid_q, out_valid_d;
  logic              out_en_q,    out_en_d;
  sec32_word_t       out_word_q,  out_word_d;

  logic              inj_pend_q, inj_pend_d;
  logic [5:0]        inj_sel_q,  inj_sel_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  sec32_parity_tree u_parity_tree (
    .data_i    (in_data),
    .nib_par_o (nib_par_s),
    .col_lo_o  (col_lo_s),
    .col_hi_o  (col_hi_s)
  );

  assign s2_load_s  = !out_valid_q || out_ready;
  assign s1_adv_s   = !s1_valid_q || s2_load_s;
  assign in_fire_s  = in_valid && s1_adv_s;
  assign out_fire_s = out_valid_q && out_ready;
  assign arm_ok_s   = inj_arm && (inj_sel <= INJ_SEL_MAX);

  // Next-state for both pipeline stages, the injection arm and the counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_nib_d    = s1_nib_q;
    s1_clo_d    = s1_clo_q;
    s1_chi_d    = s1_chi_q;
    s1_mask_d   = s1_mask_q;
    out_valid_d = out_valid_q;
    out_en_d    = out_en_q;
    out_word_d  = out_word_q;
    inj_pend_d  = inj_pend_q;
    inj_sel_d   = inj_sel_q;
    word_cnt_d  = word_cnt_q;

    if (s1_adv_s) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_nib_d  = nib_par_s;
        s1_clo_d  = col_lo_s;
        s1_chi_d  = col_hi_s;
        // Uses the arm state from before this cycle, so a same-cycle arm skips this word.
        if (inj_pend_q) begin
          s1_mask_d = sec32_inj_mask(inj_sel_q);
        end else begin
          s1_mask_d = '0;
        end
      end else begin
        s1_mask_d = s1_mask_q;
      end
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s2_load_s) begin
      out_valid_d = s1_valid_q;
      out_en_d    = s1_valid_q;
      if (s1_valid_q) begin
        // Check bits come from clean data; the mask is applied afterwards.
        out_word_d.data  = s1_data_q ^ s1_mask_q[DATA_W-1:0];
        out_word_d.check = sec32_combine(s1_nib_q, s1_clo_q, s1_chi_q)
                           ^ s1_mask_q[INJ_W-1:DATA_W];
      end else begin
        out_word_d = out_word_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end

    if (arm_ok_s) begin
      inj_pend_d = 1'b1;
      inj_sel_d  = inj_sel;
    end else if (in_fire_s) begin
      inj_pend_d = 1'b0;
    end else begin
      inj_pend_d = inj_pend_q;
    end

    if (out_fire_s) begin
      word_cnt_d = word_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // State registers with synchronous reset that drops all in-flight words.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_nib_q    <= '0;
      s1_clo_q    <= '0;
      s1_chi_q    <= '0;
      s1_mask_q   <= '0;
      out_valid_q <= 1'b0;
      out_en_q    <= 1'b0;
      out_word_q  <= '0;
      inj_pend_q  <= 1'b0;
      inj_sel_q   <= 6'd0;
      word_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_nib_q    <= s1_nib_d;
      s1_clo_q    <= s1_clo_d;
      s1_chi_q    <= s1_chi_d;
      s1_mask_q   <= s1_mask_d;
      out_valid_q <= out_valid_d;
      out_en_q    <= out_en_d;
      out_word_q  <= out_word_d;
      inj_pend_q  <= inj_pend_d;
      inj_sel_q   <= inj_sel_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign in_ready    = s1_adv_s;
  assign out_valid   = out_valid_q;
  assign out_en      = out_en_q;
  assign out_data    = out_word_q.data;
  assign out_check   = out_word_q.check;
  assign inj_pending = inj_pend_q;
  assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_sec32_check_encoder.sv
// Self-checking bench for sec32_check_encoder: vector table, scoreboard queue,
// flow-control/injection model and hand-written reset and latency sequences.
module tb_sec32_check_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [7:0]  out_check;
  logic        out_en;
  logic        inj_arm;
  logic [5:0]  inj_sel;
  logic        inj_pending;
  logic [15:0] word_cnt;

  sec32_check_encoder #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_check   (out_check),
    .out_en      (out_en),
    .inj_arm     (inj_arm),
    .inj_sel     (inj_sel),
    .inj_pending (inj_pending),
    .word_cnt    (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  c;
  } exp_t;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  check;
  } vec_t;

  localparam logic [31:0] M [8] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  logic        m_pend = 1'b0;
  logic [5:0]  m_sel = 6'd0;
  logic [15:0] m_cnt = 16'd0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_d = 32'd0;
  logic [7:0]  prev_c = 8'd0;
  logic        last_in_fire = 1'b0;
  logic        toggle_mode = 1'b0;
  logic        ovr_valid = 1'b0;
  logic [7:0]  ovr_check = 8'd0;
  int          cyc = 0;
  vec_t        tbl[8];

  function automatic logic [7:0] ref_check(input logic [31:0] d);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = ^(d & M[k]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: observe at negedge, update the model, then step past the posedge.
  task automatic tick();
    exp_t e;
    exp_t m;
    logic in_fire;
    logic out_fire;
    @(negedge clk);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    last_in_fire = 1'b0;
    if (rst) begin
      sb_q.delete();
      m_pend = 1'b0;
      m_cnt = 16'd0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", in_ready, !(sb_q.size() == 2 && !out_ready));
      chk("inj_pending", inj_pending, m_pend);
      chk("word_cnt", word_cnt, m_cnt);
      if (out_valid) chk("out_en", out_en, 1'b1);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev_d);
        chk("stall_check", out_check, prev_c);
      end
      if (out_fire) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_word", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", out_data, e.d);
          chk("out_check", out_check, e.c);
        end
        m_cnt = m_cnt + 16'd1;
      end
      if (in_fire) begin
        last_in_fire = 1'b1;
        m = '0;
        if (m_pend) begin
          if (m_sel < 6'd32) m.d[m_sel[4:0]] = 1'b1;
          else               m.c[m_sel[2:0]] = 1'b1;
        end
        e.d = in_data ^ m.d;
        e.c = (ovr_valid ? ovr_check : ref_check(in_data)) ^ m.c;
        ovr_valid = 1'b0;
        sb_q.push_back(e);
      end
      if (inj_arm && inj_sel <= 6'd39) begin
        m_pend = 1'b1;
        m_sel  = inj_sel;
      end else if (in_fire) begin
        m_pend = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data;
      prev_c = out_check;
    end
    @(posedge clk);
    #1;
    cyc++;
    inj_arm = 1'b0;
    if (toggle_mode) out_ready = (cyc % 3 == 0);
  endtask

  task automatic send_word(input logic [31:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    tick();
    while (!last_in_fire && n < 20) begin
      tick();
      n++;
    end
    if (!last_in_fire) chk("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    in_valid = 1'b0;
    for (int i = 0; i < 60 && sb_q.size() > 0; i++) tick();
    chk("drain_empty", sb_q.size(), 0);
  endtask

  task automatic latency_check(input logic [31:0] d);
    in_valid  = 1'b1;
    in_data   = d;
    out_ready = 1'b1;
    tick();
    chk("lat_accept", last_in_fire, 1'b1);
    in_valid = 1'b0;
    chk("lat_cycle1_valid", out_valid, 1'b0);
    tick();
    chk("lat_cycle2_valid", out_valid, 1'b1);
    tick();
  endtask

  task automatic arm(input logic [5:0] sel);
    in_valid = 1'b0;
    inj_arm  = 1'b1;
    inj_sel  = sel;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired (t=%0t)", $time);
    $fatal(1);
  end

  initial begin
    tbl[0] = '{32'h00000000, 8'h00};
    tbl[1] = '{32'h00000001, 8'h51};
    tbl[2] = '{32'h80000000, 8'h8A};
    tbl[3] = '{32'hFFFFFFFF, 8'h00};
    tbl[4] = '{32'h00010000, 8'h15};
    tbl[5] = '{32'h00000010, 8'h91};
    tbl[6] = '{32'h0000000F, 8'h0F};
    tbl[7] = '{32'h80000001, 8'hDB};

    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b1;
    inj_arm = 1'b0; inj_sel = 6'd0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_word_cnt", word_cnt, 16'd0);
    chk("rst_inj_pending", inj_pending, 1'b0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_check", out_check, 8'd0);
    chk("rst_out_en", out_en, 1'b0);

    ovr_valid = 1'b1; ovr_check = 8'h00;
    latency_check(32'h00000000);
    chk("first_word_cnt", word_cnt, 16'd1);

    for (int i = 0; i < 8; i++) begin
      ovr_valid = 1'b1;
      ovr_check = tbl[i].check;
      send_word(tbl[i].data);
    end
    drain();

    toggle_mode = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send_word($urandom());
    drain();
    toggle_mode = 1'b0;
    out_ready = 1'b1;

    arm(6'd5);
    chk("inj5_armed", inj_pending, 1'b1);
    send_word(32'h00000000);
    send_word(32'h00000000);
    drain();
    chk("inj5_consumed", inj_pending, 1'b0);

    arm(6'd34);
    send_word(32'h00000001);
    drain();

    arm(6'd45);
    chk("inj45_ignored", inj_pending, 1'b0);
    send_word(32'h12345678);
    drain();

    arm(6'd1);
    arm(6'd33);
    send_word(32'hA5A5A5A5);
    drain();

    inj_arm = 1'b1;
    inj_sel = 6'd7;
    send_word(32'h00000000);
    send_word(32'h00000000);
    drain();

    out_ready = 1'b0;
    send_word(32'hDEADBEEF);
    send_word(32'h01234567);
    arm(6'd9);
    chk("pre_rst_in_ready", in_ready, 1'b0);
    chk("pre_rst_pending", inj_pending, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_word_cnt", word_cnt, 16'd0);
    chk("mid_rst_pending", inj_pending, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    latency_check(32'h80000000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sec32_check_encoder.md
Name: sec32_check_encoder

Overview:
- Upstream companion to the 32-bit single-error-correcting (SEC) corrector stage.
- Takes 32-bit data words over a valid/ready stream and computes the 8 check bits the corrector expects.
- Emits data, check bits and the corrector-enable bit as one registered bundle.
- Has a one-shot single-bit error-injection hook, so the corrector path can be exercised in-system.
- Two-stage pipeline with full backpressure; one word per cycle at full throughput.

Parameters:
- DATA_W, 32, data width; fixed, because the check equations are defined for 32 bits only.
- CHK_W, 8, check-bit width; fixed.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: one clock, synchronous, active-high.
- in_valid, in, 1, input word valid.
- in_ready, out, 1, input word accepted when in_valid & in_ready.
- in_data, in, 32, data; d[i] corresponds to corrector data input i+1.
- out_valid, out, 1, output bundle valid.
- out_ready, in, 1, downstream accepts the bundle.
- out_data, out, 32, data, possibly with one injected flip.
- out_check, out, 8, check bits c[7:0].
- out_en, out, 1, corrector enable; 1 whenever out_valid is 1.
- inj_arm, in, 1, pulse that arms a one-shot injection.
- inj_sel, in, 6, injection position: 0-31 flips out_data[inj_sel]; 32-39 flips out_check[inj_sel-32]; 40-63 arms nothing.
- inj_pending, out, 1, an armed injection is not yet consumed.
- word_cnt, out, CNT_W, number of bundles delivered (out handshakes), wraps.

Behaviour:
- Check equations (XOR over the listed d bits):
  - c0 = d16..d23, d0, d4, d8, d12
  - c1 = d24..d31, d1, d5, d9, d13
  - c2 = d16..d19, d24..d27, d2, d6, d10, d14
  - c3 = d20..d23, d28..d31, d3, d7, d11, d15
  - c4 = d0..d7, d16, d20, d24, d28
  - c5 = d8..d15, d17, d21, d25, d29
  - c6 = d0..d3, d8..d11, d18, d22, d26, d30
  - c7 = d4..d7, d12..d15, d19, d23, d27, d31
- Stage S1 registers: data, eight nibble parities g[k] = xor d[4k+3:4k], four column parities x[j] = xor of d[j+4m] for m=0..3, and the injection mask.
- Stage S2 (output register) combines these into c0..c7, then applies the mask.
- Latency: 2 cycles from input handshake to out_valid when there is no stall.
- Flow control:
  - s2_load = !out_valid | out_ready.
  - s1_adv = !s1_valid | s2_load.
  - in_ready = s1_adv (combinational from out_ready; no bubble).
  - A stalled output holds out_* stable until the out handshake.
- Injection:
  - inj_arm with inj_sel <= 39 sets pending and latches inj_sel.
  - inj_sel >= 40 is ignored; no state change.
  - The pending injection applies to the first word accepted in a strictly later cycle. That word's mask is set and pending clears in the same cycle as its handshake.
  - Arm while already pending: the new inj_sel overwrites; still one shot.
  - Arm in the same cycle as an input handshake: that word is clean; the next word is injected.
  - Check bits are always computed from the clean data. A data flip therefore yields a single-bit codeword error.
- word_cnt increments on out_valid & out_ready and wraps from 2^CNT_W-1 to 0.
- Reset (applies at any point, including mid-stall or mid-pipeline):
  - All in-flight words are discarded.
  - out_valid=0, s1_valid=0, out_data=0, out_check=0, out_en=0.
  - inj_pending=0, word_cnt=0.
  - in_ready is 1 in the first cycle after reset.

Decomposition:
- Shared package sec32_pkg holds:
  - DATA_W and CHK_W constants.
  - The eight 32-bit check masks CHK_MASK[0..7] (the equations above, bit i set if d_i participates).
  - Typedef sec32_word_t: data[31:0], check[7:0].
- The corrector bench reuses the same package.
- One natural sub-module: sec32_parity_tree, combinational. It computes nibble and column parities and is reused by the corrector's syndrome model in the testbench.

Test Plan:
- After reset, in_data=0x00000000 with out_ready=1 -> out_check=0x00 two cycles later; out_en=1; word_cnt=1 after the handshake.
- in_data=0x00000001 -> out_check=0x51.
- in_data=0x80000000 -> out_check=0x8A.
- in_data=0xFFFFFFFF -> out_check=0x00.
- Stream of 8 words with out_ready toggling 1,0,0,1,... -> no word lost or duplicated, order preserved, out_* stable while stalled, in_ready=0 exactly when S1 and S2 are both full and out_ready=0.
- inj_arm with inj_sel=5, then send 0x00000000 -> out_data=0x00000020, out_check=0x00, inj_pending 1->0; next word is clean.
- inj_arm with inj_sel=34 -> out_check bit 2 flipped.
- inj_sel=45 -> no effect and inj_pending stays 0.
- rst asserted while 2 words are in flight and the output is stalled -> next cycle out_valid=0, word_cnt=0, inj_pending=0, in_ready=1; a fresh word then emerges with latency 2.
